// File: rtl/box_blitter.sv
// rtl/box_blitter.sv - copies a 32x32 sprite from ROM into the framebuffer with colour-key and screen clipping
module box_blitter #(
  parameter logic [11:0] TRANSPARENT = 12'h28F,
  parameter int          SCREEN_W    = 640,
  parameter int          SCREEN_H    = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [9:0]  dest_x,
  input  logic [9:0]  dest_y,
  output logic [4:0]  rom_row,
  output logic [4:0]  rom_col,
  input  logic [11:0] color_data,
  output logic        fb_we,
  output logic [9:0]  fb_x,
  output logic [9:0]  fb_y,
  output logic [11:0] fb_data,
  input  logic        fb_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [10:0] LP_SCREEN_W = 11'(SCREEN_W);
  localparam logic [10:0] LP_SCREEN_H = 11'(SCREEN_H);

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_row;
  logic [4:0]  r_col;
  logic [9:0]  r_dest_x;
  logic [9:0]  r_dest_y;
  logic [10:0] w_sum_x;
  logic [10:0] w_sum_y;
  logic [4:0]  w_next_row;
  logic [4:0]  w_next_col;
  logic        w_in_write;
  logic        w_visible;
  logic        w_advance;
  logic        w_last_pixel;

  // Screen position of the current pixel; 11 bits so sprites hanging off the right/bottom edge clip instead of wrapping
  always_comb begin
    w_sum_x      = {1'b0, r_dest_x} + {6'd0, r_col};
    w_sum_y      = {1'b0, r_dest_y} + {6'd0, r_row};
    w_next_col   = r_col + 5'd1;
    w_next_row   = (r_col == 5'd31) ? (r_row + 5'd1) : r_row;
    w_last_pixel = (r_row == 5'd31) && (r_col == 5'd31);
  end

  // Write strobe and pixel advance: a clipped or transparent pixel still costs one cycle, a stalled write holds everything
  always_comb begin
    w_in_write = (r_state == ST_WRITE);
    w_visible  = (color_data != TRANSPARENT) && (w_sum_x < LP_SCREEN_W) && (w_sum_y < LP_SCREEN_H);
    fb_we      = w_in_write && w_visible;
    w_advance  = w_in_write && (!fb_we || fb_ready);
    fb_x       = w_in_write ? w_sum_x[9:0] : 10'd0;
    fb_y       = w_in_write ? w_sum_y[9:0] : 10'd0;
    fb_data    = w_in_write ? color_data : 12'd0;
    busy       = (r_state != ST_IDLE);
    done       = (r_state == ST_DONE);
  end

  // ROM address leads by one pixel so the registered ROM output lines up with the current pixel in WRITE
  always_comb begin
    rom_row = r_row;
    rom_col = r_col;
    if (w_advance) begin
      rom_row = w_next_row;
      rom_col = w_next_col;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_PRIME;
      ST_PRIME: w_next_state = ST_WRITE;
      ST_WRITE: if (w_advance && w_last_pixel) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State register; reset aborts any blit in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Destination latch and raster pixel counters; the counters wrap back to (0,0) after the last pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row    <= 5'd0;
      r_col    <= 5'd0;
      r_dest_x <= 10'd0;
      r_dest_y <= 10'd0;
    end else if (r_state == ST_IDLE && start) begin
      r_row    <= 5'd0;
      r_col    <= 5'd0;
      r_dest_x <= dest_x;
      r_dest_y <= dest_y;
    end else if (w_advance) begin
      r_row    <= w_next_row;
      r_col    <= w_next_col;
    end
  end

endmodule

// File: tb/tb_box_blitter.sv
// tb/tb_box_blitter.sv - scoreboard testbench for box_blitter
module tb_box_blitter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  dest_x;
  logic [9:0]  dest_y;
  logic [4:0]  rom_row;
  logic [4:0]  rom_col;
  logic [11:0] color_data = 12'd0;
  logic        fb_we;
  logic [9:0]  fb_x;
  logic [9:0]  fb_y;
  logic [11:0] fb_data;
  logic        fb_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rom_mode = 0;
  int wr_cnt = 0;
  logic [19:0] first_xy;
  logic [19:0] last_xy;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  box_blitter dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dest_x(dest_x), .dest_y(dest_y),
    .rom_row(rom_row), .rom_col(rom_col), .color_data(color_data),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data), .fb_ready(fb_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [11:0] rom_f(input logic [4:0] r, input logic [4:0] c);
    if (rom_mode == 1 && c[0] == 1'b0) return 12'h28F;
    return {r, c, 2'b01};
  endfunction

  // Registered sprite ROM model
  always @(posedge clk) color_data <= rom_f(rom_row, rom_col);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted write is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (reset_n && fb_we && fb_ready) begin
      wr_cnt++;
      if (wr_cnt == 1) first_xy = {fb_x, fb_y};
      last_xy = {fb_x, fb_y};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual x=%0d y=%0d data=%0h required=no write", fb_x, fb_y, fb_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_xyd", {32'd0, fb_x, fb_y, fb_data}, {32'd0, mon_e});
      end
    end
  end

  task automatic fill_q(input int dx, input int dy, input int mode, input int npix);
    int r, c, x, y;
    logic [4:0] r5, c5;
    for (int p = 0; p < npix; p++) begin
      r = p / 32;
      c = p % 32;
      x = dx + c;
      y = dy + r;
      if (mode == 1 && (c % 2) == 0) continue;
      if (x >= 640 || y >= 480) continue;
      r5 = r[4:0];
      c5 = c[4:0];
      exp_q.push_back({x[9:0], y[9:0], r5, c5, 2'b01});
    end
  endtask

  task automatic run_blit(input int dx, input int dy, input int exp_cycles, input bit mid_start, input string name);
    int c0;
    bit got;
    dest_x = 10'(dx);
    dest_y = 10'(dy);
    wr_cnt = 0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 0) check({name, "_busy_prime"}, {62'd0, busy, done}, 64'd2);
      if (done) begin
        got = 1'b1;
        break;
      end
      start = (mid_start && (cyc - c0) == 500);
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no done required=done", name);
    end else begin
      check({name, "_done_cycle"}, 64'(cyc - c0 + 1), 64'(exp_cycles));
    end
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic stall_proc(input int dx, input int dy);
    logic [31:0] cap;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      if (fb_we && int'(fb_x) == dx + 7 && int'(fb_y) == dy + 3) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL stall_pixel_seen actual=not seen required=pixel (3,7)");
    end else begin
      cap = {fb_x, fb_y, fb_data};
      check("stall_pixel_value", {32'd0, cap}, {32'd0, 10'd107, 10'd53, 12'h19D});
      fb_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        check("stall_hold", {31'd0, fb_we, fb_x, fb_y, fb_data}, {31'd0, 1'b1, cap});
      end
      fb_ready = 1'b1;
    end
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    start = 1'b0;
    fb_ready = 1'b1;
    dest_x = 10'd0;
    dest_y = 10'd0;
    repeat (3) @(negedge clk);
    check("rst_fb_we", {63'd0, fb_we}, 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    check("rst_rom", {54'd0, rom_row, rom_col}, 64'd0);
    check("rst_fb_xy", {44'd0, fb_x, fb_y}, 64'd0);
    check("rst_fb_data", {52'd0, fb_data}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full sprite, with a start pulse mid-blit that must be ignored
    rom_mode = 0;
    fill_q(100, 50, 0, 1024);
    run_blit(100, 50, 1026, 1'b1, "t1");
    check("t1_writes", 64'(wr_cnt), 64'd1024);
    check("t1_first", {44'd0, first_xy}, {44'd0, 10'd100, 10'd50});
    check("t1_last", {44'd0, last_xy}, {44'd0, 10'd131, 10'd81});
    repeat (3) @(negedge clk);
    check("t1_idle_after", {62'd0, busy, done}, 64'd0);

    // Transparent even columns
    rom_mode = 1;
    fill_q(100, 50, 1, 1024);
    run_blit(100, 50, 1026, 1'b0, "t2");
    check("t2_writes", 64'(wr_cnt), 64'd512);
    check("t2_first", {44'd0, first_xy}, {44'd0, 10'd101, 10'd50});

    // Clipping at the bottom-right corner
    rom_mode = 0;
    fill_q(620, 470, 0, 1024);
    run_blit(620, 470, 1026, 1'b0, "t3");
    check("t3_writes", 64'(wr_cnt), 64'd200);
    check("t3_first", {44'd0, first_xy}, {44'd0, 10'd620, 10'd470});
    check("t3_last", {44'd0, last_xy}, {44'd0, 10'd639, 10'd479});

    // Backpressure for 5 cycles on pixel (3,7)
    fill_q(100, 50, 0, 1024);
    fork
      run_blit(100, 50, 1031, 1'b0, "t4");
      stall_proc(100, 50);
    join
    check("t4_writes", 64'(wr_cnt), 64'd1024);

    // Reset at pixel (10,0) aborts the blit
    fill_q(100, 50, 0, 320);
    dest_x = 10'd100;
    dest_y = 10'd50;
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      if (fb_we && fb_x == 10'd100 && fb_y == 10'd60) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_reached_10_0", {63'd0, found}, 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_fb_we", {63'd0, fb_we}, 64'd0);
    check("t5_rst_busy", {62'd0, busy, done}, 64'd0);
    check("t5_rst_rom", {54'd0, rom_row, rom_col}, 64'd0);
    check("t5_writes_before", 64'(wr_cnt), 64'd320);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_idle_after_release", {62'd0, busy, done}, 64'd0);
    check("t5_no_resume", 64'(wr_cnt), 64'd320);

    // A fresh blit after the abort completes normally
    fill_q(100, 50, 0, 1024);
    run_blit(100, 50, 1026, 1'b0, "t6");
    check("t6_writes", 64'(wr_cnt), 64'd1024);
    check("t6_last", {44'd0, last_xy}, {44'd0, 10'd131, 10'd81});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/box_blitter.md
BOX_BLITTER -- requirements
Module: box_blitter

Interface
REQ-001 SHALL have parameter TRANSPARENT, default 12'h28F, the colour key that is never written to the framebuffer.
REQ-002 SHALL have parameter SCREEN_W, default 640, the visible width; pixels at or beyond it are clipped.
REQ-003 SHALL have parameter SCREEN_H, default 480, the visible height; pixels at or beyond it are clipped.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: blit request, sampled only in IDLE.
REQ-007 SHALL have port dest_x, input, 10 bits: screen x of sprite column 0, latched on start.
REQ-008 SHALL have port dest_y, input, 10 bits: screen y of sprite row 0, latched on start.
REQ-009 SHALL have port rom_row, output, 5 bits: row address to the 32x32 box sprite ROM.
REQ-010 SHALL have port rom_col, output, 5 bits: column address to the sprite ROM.
REQ-011 SHALL have port color_data, input, 12 bits: ROM pixel, valid one clock after rom_row/rom_col are registered by the ROM.
REQ-012 SHALL have port fb_we, output, 1 bit: framebuffer write strobe.
REQ-013 SHALL have port fb_x, output, 10 bits: framebuffer write x.
REQ-014 SHALL have port fb_y, output, 10 bits: framebuffer write y.
REQ-015 SHALL have port fb_data, output, 12 bits: framebuffer write colour.
REQ-016 SHALL have port fb_ready, input, 1 bit: framebuffer accepts a write on the edge where fb_we and fb_ready are both high.
REQ-017 SHALL have port busy, output, 1 bit: high in PRIME, WRITE and DONE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse in DONE.

Function
REQ-019 SHALL implement the states IDLE, PRIME, WRITE and DONE.
REQ-020 SHALL, in IDLE with start high: latch dest_x/dest_y, set the current pixel (cur_row, cur_col) to (0,0), and go to PRIME; start SHALL be ignored in every other state.
REQ-021 SHALL spend exactly one cycle in PRIME, then go to WRITE.
REQ-022 SHALL drive rom_row/rom_col combinationally with the pixel that will be current in the next cycle, so that color_data in WRITE always belongs to (cur_row, cur_col): value (0,0) in IDLE, PRIME and stalled cycles hold the current pixel, an advancing cycle presents the next pixel.
REQ-023 SHALL, in WRITE, drive fb_x = dest_x + cur_col and fb_y = dest_y + cur_row, with the sums computed at 11 bits and the low 10 bits output; fb_data SHALL equal color_data.
REQ-024 SHALL assert fb_we in WRITE only when color_data != TRANSPARENT, the 11-bit x sum < SCREEN_W and the 11-bit y sum < SCREEN_H; fb_we SHALL be 0 in all other states.
REQ-025 SHALL advance the pixel when fb_we is 0 or fb_ready is 1; it SHALL hold the pixel and all fb_* outputs when fb_we is 1 and fb_ready is 0.
REQ-026 SHALL advance in raster order, incrementing cur_col and, when cur_col wraps from 31 to 0, incrementing cur_row.
REQ-027 SHALL go from WRITE to DONE when pixel (31,31) advances, then from DONE to IDLE after one cycle.
REQ-028 SHALL have a throughput of 1 pixel per clock with fb_ready held high: start accepted at edge 0, PRIME in cycle 1, WRITE in cycles 2-1025, DONE in cycle 1026.

Reset
REQ-029 SHALL, while reset_n is low: hold state IDLE, cur_row/cur_col/dest = 0, and outputs fb_we=0, busy=0, done=0, rom_row=rom_col=0, fb_x=fb_y=0, fb_data=0.
REQ-030 SHALL abort an in-progress blit when reset is asserted, with fb_we dropping without waiting for a clock edge, and SHALL not resume the blit after release.

Verification
REQ-031 SHALL cover: ROM model returns {row,col,2'b01}, dest (100,50), fb_ready=1 -> 1024 writes in raster order, the first write at (100,50) and the last at (131,81), done in cycle 1026.
REQ-032 SHALL cover: ROM returns TRANSPARENT for even columns -> exactly 512 writes, all at odd columns, and the same 1026-cycle completion.
REQ-033 SHALL cover: dest (620,470) -> writes only for x 620-639 and y 470-479 (200 writes), with clipped pixels consuming one cycle each.
REQ-034 SHALL cover: fb_ready low for 5 cycles during pixel (3,7) -> fb_x/fb_y/fb_data held stable, no duplicate or lost write, done delayed by exactly 5 cycles.
REQ-035 SHALL cover: start pulsed again mid-blit -> ignored; reset_n pulled low at pixel (10,0) -> fb_we=0 immediately, IDLE after release, and a new start completes normally.
